// File: rtl/core_seq_pkg.sv
// Shared types and constants for the core run controller.
package core_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_PRIME = 3'd2,
    S_RUN   = 3'd3,
    S_PAUSE = 3'd4,
    S_DONE  = 3'd5
  } seq_state_t;

  localparam int unsigned IW_DEF = 9;

  // The halt instruction is the all-ones machine word.
  localparam logic [IW_DEF-1:0] HALT_CODE = '1;

endpackage

// File: rtl/core_sequencer_ret_counter.sv
// Retired-instruction counter: synchronous clear, count enable, and a flag
// raised while the value sits one below the instruction budget.
module ret_counter #(
  parameter int          CW      = 16,
  parameter logic [CW-1:0] MAX_CYC = '1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          en,
  output logic [CW-1:0] value,
  output logic          last
);

  // NOTE: sequential state is always written with non-blocking assignments so
  // every register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
    end else if (clear) begin
      value <= '0;
    end else if (en) begin
      value <= value + CW'(1);
    end
  end

  // The enabled cycle that sees last is the final one within budget, so the
  // value peaks at MAX_CYC and never wraps.
  assign last = (value == MAX_CYC - CW'(1));

endmodule

// File: rtl/core_sequencer.sv
// Run controller for the single-cycle 9-bit core: loader/core arbitration of
// the data-memory write port, PC priming, run/single-step gating, halt/budget.
module core_sequencer
  import core_seq_pkg::*;
#(
  parameter int            AW      = 8,
  parameter int            DW      = 8,
  parameter int            IW      = IW_DEF,
  parameter int            CW      = 16,
  parameter logic [CW-1:0] MAX_CYC = 16'hFFFF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          step_mode,
  input  logic          step,
  input  logic          ld_req,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_wdata,
  input  logic          ld_we,
  output logic          ld_gnt,
  input  logic [IW-1:0] mach_code,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  input  logic          core_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  output logic          pc_rst,
  output logic          core_en,
  output logic          busy,
  output logic          done,
  output logic          timeout,
  output logic [CW-1:0] instr_cnt
);

  seq_state_t state, next_state;
  logic       halt;
  logic       last;
  logic       cnt_clear;
  logic       timeout_set;
  logic       timeout_clr;

  assign halt = (mach_code == HALT_CODE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    next_state  = state;
    pc_rst      = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    ld_gnt      = 1'b0;
    core_en     = 1'b0;
    cnt_clear   = 1'b0;
    timeout_set = 1'b0;
    timeout_clr = 1'b0;

    unique case (state)
      S_IDLE: begin
        pc_rst = 1'b1;
        if (ld_req)     next_state = S_LOAD;
        else if (start) next_state = S_PRIME;
      end

      S_LOAD: begin
        ld_gnt = 1'b1;
        pc_rst = 1'b1;
        if (!ld_req) next_state = S_IDLE;
      end

      S_PRIME: begin
        pc_rst      = 1'b1;
        busy        = 1'b1;
        cnt_clear   = 1'b1;
        timeout_clr = 1'b1;
        next_state  = step_mode ? S_PAUSE : S_RUN;
      end

      S_RUN: begin
        busy    = 1'b1;
        core_en = !halt;
        if (halt) begin
          next_state = S_DONE;
        end else if (last) begin
          next_state  = S_DONE;
          timeout_set = 1'b1;
        end else if (step_mode) begin
          next_state = S_PAUSE;
        end
      end

      S_PAUSE: begin
        busy    = 1'b1;
        core_en = step && !halt;
        if (halt) begin
          next_state = S_DONE;
        end else if (core_en && last) begin
          next_state  = S_DONE;
          timeout_set = 1'b1;
        end else if (!step_mode) begin
          next_state = S_RUN;
        end
      end

      S_DONE: begin
        done = 1'b1;
        if (ld_req) begin
          next_state  = S_LOAD;
          timeout_clr = 1'b1;
        end else if (start) begin
          next_state  = S_PRIME;
          timeout_clr = 1'b1;
        end
      end

      default: begin
        pc_rst     = 1'b1;
        next_state = S_IDLE;
      end
    endcase
  end

  ret_counter #(
    .CW      (CW),
    .MAX_CYC (MAX_CYC)
  ) u_ret_counter (
    .clk   (clk),
    .rst   (reset),
    .clear (cnt_clear),
    .en    (core_en),
    .value (instr_cnt),
    .last  (last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timeout <= 1'b0;
    end else if (timeout_set) begin
      timeout <= 1'b1;
    end else if (timeout_clr) begin
      timeout <= 1'b0;
    end
  end

  // Core stores only reach memory on cycles that actually execute.
  assign mem_addr  = ld_gnt ? ld_addr  : core_addr;
  assign mem_wdata = ld_gnt ? ld_wdata : core_wdata;
  assign mem_we    = ld_gnt ? ld_we    : (core_we && core_en);

endmodule

// File: tb/tb_core_sequencer.sv
// Directed and randomized checks of core_sequencer; two instances share the
// stimulus, one with the full budget and one with a budget of four.
module tb_core_sequencer;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int IW = 9;
  localparam int CW = 16;
  localparam logic [IW-1:0] HALT_W = 9'h1FF;

  localparam int P_IDLE   = 0;
  localparam int P_PRIME  = 1;
  localparam int P_ACTIVE = 2;
  localparam int P_FIN    = 3;

  logic          clk = 1'b0;
  logic          reset, start, step_mode, step, ld_req, ld_we, core_we;
  logic [AW-1:0] ld_addr, core_addr;
  logic [DW-1:0] ld_wdata, core_wdata;

  logic [IW-1:0] mach_a, mach_b;
  logic          ld_gnt_a, mem_we_a, pc_rst_a, core_en_a, busy_a, done_a, timeout_a;
  logic          ld_gnt_b, mem_we_b, pc_rst_b, core_en_b, busy_b, done_b, timeout_b;
  logic [AW-1:0] mem_addr_a, mem_addr_b;
  logic [DW-1:0] mem_wdata_a, mem_wdata_b;
  logic [CW-1:0] instr_cnt_a, instr_cnt_b;

  logic [IW-1:0] prog [256];
  logic [7:0]    pc_a, pc_b;

  int total = 0;
  int bad   = 0;

  int m_ph    [2];
  int m_cnt   [2];
  int m_pc    [2];
  bit m_pause [2];
  bit m_to    [2];
  int budget  [2] = '{65535, 4};

  always #5 clk = ~clk;

  core_sequencer u_dut_a (
    .clk(clk), .reset(reset), .start(start), .step_mode(step_mode), .step(step),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_we(ld_we),
    .ld_gnt(ld_gnt_a), .mach_code(mach_a), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_we(core_we), .mem_addr(mem_addr_a),
    .mem_wdata(mem_wdata_a), .mem_we(mem_we_a), .pc_rst(pc_rst_a),
    .core_en(core_en_a), .busy(busy_a), .done(done_a), .timeout(timeout_a),
    .instr_cnt(instr_cnt_a)
  );

  core_sequencer #(.MAX_CYC(16'd4)) u_dut_b (
    .clk(clk), .reset(reset), .start(start), .step_mode(step_mode), .step(step),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_we(ld_we),
    .ld_gnt(ld_gnt_b), .mach_code(mach_b), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_we(core_we), .mem_addr(mem_addr_b),
    .mem_wdata(mem_wdata_b), .mem_we(mem_we_b), .pc_rst(pc_rst_b),
    .core_en(core_en_b), .busy(busy_b), .done(done_b), .timeout(timeout_b),
    .instr_cnt(instr_cnt_b)
  );

  // Program counters of the surrounding core, one per instance.
  assign mach_a = prog[pc_a];
  assign mach_b = prog[pc_b];

  always @(posedge clk or posedge reset) begin
    if (reset)          pc_a <= '0;
    else if (pc_rst_a)  pc_a <= '0;
    else if (core_en_a) pc_a <= pc_a + 8'd1;
  end

  always @(posedge clk or posedge reset) begin
    if (reset)          pc_b <= '0;
    else if (pc_rst_b)  pc_b <= '0;
    else if (core_en_b) pc_b <= pc_b + 8'd1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic load_prog(input int n_instr, input int halt_at);
    for (int i = 0; i < 256; i++) prog[i] = '0;
    for (int i = 0; i < n_instr; i++) prog[i] = IW'(i + 1);
    prog[halt_at] = HALT_W;
  endtask

  task automatic run_to_done(output int n_a);
    n_a = 0;
    for (int i = 0; i < 40; i++) begin
      settle();
      if (done_a && done_b) break;
      if (core_en_a) n_a++;
      tick();
    end
    check("run_bound", {31'd0, done_a & done_b}, 32'd1);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_ph[k] = P_IDLE; m_cnt[k] = 0; m_pc[k] = 0; m_pause[k] = 1'b0; m_to[k] = 1'b0;
    end
  endtask

  // Compares one instance against the model for the current cycle, then
  // advances the model across the coming clock edge.
  task automatic model_cycle(input int k);
    bit halt_m, exp_en;
    halt_m = (prog[m_pc[k]] == HALT_W);
    exp_en = (m_ph[k] == P_ACTIVE) && !halt_m && (!m_pause[k] || step);
    check($sformatf("rnd%0d_en", k),   {31'd0, k ? core_en_b : core_en_a}, {31'd0, exp_en});
    check($sformatf("rnd%0d_busy", k), {31'd0, k ? busy_b : busy_a},
          {31'd0, m_ph[k] == P_PRIME || m_ph[k] == P_ACTIVE});
    check($sformatf("rnd%0d_done", k), {31'd0, k ? done_b : done_a}, {31'd0, m_ph[k] == P_FIN});
    check($sformatf("rnd%0d_to", k),   {31'd0, k ? timeout_b : timeout_a}, {31'd0, m_to[k]});
    check($sformatf("rnd%0d_cnt", k),  {16'd0, k ? instr_cnt_b : instr_cnt_a}, m_cnt[k]);
    case (m_ph[k])
      P_IDLE, P_FIN: if (start) begin m_ph[k] = P_PRIME; m_to[k] = 1'b0; end
      P_PRIME: begin
        m_cnt[k] = 0; m_to[k] = 1'b0; m_pc[k] = 0;
        m_pause[k] = step_mode; m_ph[k] = P_ACTIVE;
      end
      P_ACTIVE: begin
        if (halt_m) begin
          m_ph[k] = P_FIN;
        end else if (exp_en) begin
          m_cnt[k]++;
          m_pc[k]++;
          if (m_cnt[k] == budget[k]) begin
            m_ph[k] = P_FIN; m_to[k] = 1'b1;
          end else begin
            m_pause[k] = step_mode;
          end
        end else begin
          m_pause[k] = step_mode;
        end
      end
      default: m_ph[k] = P_IDLE;
    endcase
  endtask

  initial begin
    int n_en;
    int len;

    reset = 1'b1; start = 1'b0; step_mode = 1'b0; step = 1'b0;
    ld_req = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_wdata = '0;
    core_we = 1'b0; core_addr = '0; core_wdata = '0;
    load_prog(5, 5);
    tick();
    settle();
    check("rst_pc_rst", {31'd0, pc_rst_a}, 32'd1);
    check("rst_idle_outs", {27'd0, core_en_a, busy_a, done_a, timeout_a, ld_gnt_a}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we_a}, 32'd0);
    check("rst_cnt", {16'd0, instr_cnt_a}, 32'd0);
    reset = 1'b0;
    tick();

    // Loader and start together in IDLE: loader wins; core store is ignored.
    ld_req = 1'b1; start = 1'b1;
    tick();
    ld_addr = 8'h10; ld_wdata = 8'hA5; ld_we = 1'b1;
    core_we = 1'b1; core_addr = 8'h33; core_wdata = 8'h5C;
    settle();
    check("ld_gnt", {31'd0, ld_gnt_a}, 32'd1);
    check("ld_mem_we", {31'd0, mem_we_a}, 32'd1);
    check("ld_mem_addr", {24'd0, mem_addr_a}, 32'h10);
    check("ld_mem_wdata", {24'd0, mem_wdata_a}, 32'hA5);
    check("ld_not_busy", {31'd0, busy_a}, 32'd0);
    ld_we = 1'b0;
    settle();
    check("ld_we_low", {31'd0, mem_we_a}, 32'd0);
    tick();
    settle();
    check("ld_start_ignored", {30'd0, ld_gnt_a, busy_a}, 32'b10);
    ld_req = 1'b0; start = 1'b0;
    tick();
    settle();
    check("idle_after_ld", {30'd0, ld_gnt_a, pc_rst_a}, 32'b01);
    check("idle_mux", {23'd0, mem_addr_a, mem_we_a}, {23'd0, 8'h33, 1'b0});

    // Free run: five instructions then halt; the small-budget copy times out.
    start = 1'b1;
    tick();
    start = 1'b0;
    settle();
    check("prime_outs", {29'd0, pc_rst_a, busy_a, core_en_a}, 32'b110);
    tick();
    settle();
    check("first_exec", {30'd0, core_en_a, mem_we_a}, 32'b11);
    run_to_done(n_en);
    check("run_en_cycles", n_en, 32'd4 + 32'd1);
    check("run_cnt", {16'd0, instr_cnt_a}, 32'd5);
    check("run_flags", {29'd0, done_a, timeout_a, busy_a}, 32'b100);
    check("done_no_store", {30'd0, mem_we_a, core_en_a}, 32'd0);
    check("budget_cnt", {16'd0, instr_cnt_b}, 32'd4);
    check("budget_flags", {30'd0, done_b, timeout_b}, 32'b11);

    // Contention in DONE: loader wins, timeout leaves with DONE.
    ld_req = 1'b1; start = 1'b1;
    tick();
    settle();
    check("done_ld_wins", {29'd0, ld_gnt_a, busy_a, done_a}, 32'b100);
    check("done_exit_to", {31'd0, timeout_b}, 32'd0);
    check("ld_keeps_cnt", {16'd0, instr_cnt_a}, 32'd5);
    ld_req = 1'b0; start = 1'b0;
    tick();

    // Halt arrives on the budget cycle of the small-budget copy: halt wins.
    load_prog(3, 3);
    start = 1'b1;
    tick();
    start = 1'b0;
    run_to_done(n_en);
    check("hb_cnt_a", {16'd0, instr_cnt_a}, 32'd3);
    check("hb_cnt_b", {16'd0, instr_cnt_b}, 32'd3);
    check("hb_to_b", {31'd0, timeout_b}, 32'd0);

    // Single-step: three pulses over ten cycles.
    load_prog(5, 5);
    step_mode = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    n_en = 0;
    for (int i = 0; i < 10; i++) begin
      step = (i % 3 == 1);
      settle();
      if (core_en_a) n_en++;
      tick();
    end
    step = 1'b0;
    settle();
    check("step_en_cycles", n_en, 32'd3);
    check("step_cnt", {16'd0, instr_cnt_a}, 32'd3);
    check("step_busy", {30'd0, busy_a, done_a}, 32'b10);
    step_mode = 1'b0;
    run_to_done(n_en);
    check("step_resume_cnt", {16'd0, instr_cnt_a}, 32'd5);
    check("step_resume_b", {15'd0, timeout_b, instr_cnt_b}, {15'd0, 1'b1, 16'd4});

    // Asynchronous reset in the middle of a run.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    settle();
    check("pre_rst_running", {31'd0, core_en_a}, 32'd1);
    reset = 1'b1;
    settle();
    check("mid_rst_outs", {29'd0, pc_rst_a, core_en_a, mem_we_a}, 32'b100);
    check("mid_rst_cnt", {16'd0, instr_cnt_a}, 32'd0);
    reset = 1'b0;
    core_we = 1'b0;
    tick();

    // Randomized runs against the reference model.
    model_reset();
    for (int r = 0; r < 10; r++) begin
      len = $urandom_range(1, 10);
      for (int i = 0; i < 256; i++) prog[i] = '0;
      for (int i = 0; i < len; i++) prog[i] = IW'($urandom_range(0, 510));
      prog[len] = HALT_W;
      step_mode = 1'($urandom_range(0, 1));
      for (int c = 0; c < 150; c++) begin
        start = (c == 0);
        if ($urandom_range(0, 3) == 0) step_mode = ~step_mode;
        step = ($urandom_range(0, 2) == 0);
        settle();
        model_cycle(0);
        model_cycle(1);
        tick();
        if (m_ph[0] == P_FIN && m_ph[1] == P_FIN) break;
      end
      start = 1'b0; step = 1'b0;
      check("rnd_bound", {31'd0, m_ph[0] == P_FIN && m_ph[1] == P_FIN}, 32'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
